// File: rtl/nes_pad_responder_if.sv
// -----------------------------------------------------------------------------
// nes_pad_responder_if
//   Three-wire NES/SNES pad bus between a console-side host and a pad.
//
//   nes_latch_in  host -> pad  latch strobe, active-high, asynchronous to clk
//   nes_clk_in    host -> pad  shift clock, pad shifts on its rising edge
//   nes_data_out  pad -> host  serial button data, active-low (0 = pressed)
//
//   Modports:
//     master : the host side (drives latch and clock, samples data)
//     slave  : the pad side  (samples latch and clock, drives data)
// -----------------------------------------------------------------------------
interface nes_pad_responder_if;
  logic nes_latch_in;
  logic nes_clk_in;
  logic nes_data_out;

  modport master (
    output nes_latch_in,
    output nes_clk_in,
    input  nes_data_out
  );

  modport slave (
    input  nes_latch_in,
    input  nes_clk_in,
    output nes_data_out
  );
endinterface

// File: rtl/nes_pad_responder.sv
// -----------------------------------------------------------------------------
// nes_pad_responder
//   Pad-side end of the NES serial pad protocol. Emulates a 4021-style shift
//   register pad: a latch pulse loads the buttons, each host clock rise shifts
//   the next button onto the active-low serial line.
//
//   Host latch/clock are asynchronous; each passes through SYNC_STAGES flops
//   and one edge-detect flop. Edges are acted on one cycle after detection,
//   so a pin edge reaches nes_data_out SYNC_STAGES+1 clk cycles later.
//
//   Build option: define NES_PAD_SNES_EN for SNES mode (12 buttons, 16-bit
//   frame, bits 12-15 shift out as released, bit_idx saturates at 16 and is
//   therefore 5 bits wide). Undefined: 8-button NES frame.
//
//   Ports:
//     clk          system clock
//     rst_n        asynchronous active-low reset
//     buttons      active-high pressed
//                  NES : [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right
//                  SNES: [0]B [1]Y [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right
//                        [8]A [9]X [10]L [11]R
//     pad          slave side of the pad bus (latch, clock in; data out)
//     poll_strobe  one-cycle pulse when the synchronized latch falls in LOAD
//     bit_idx      bits shifted since the last load, saturating at frame size
//     host_active  a latch rise was seen within the last TIMEOUT_CYCLES cycles
// -----------------------------------------------------------------------------
module nes_pad_responder #(
  parameter int SYNC_STAGES    = 2,        // min 2
  parameter int TIMEOUT_CYCLES = 1000000   // must fit in 24 bits
) (
  input  logic                      clk,
  input  logic                      rst_n,
`ifdef NES_PAD_SNES_EN
  input  logic [11:0]               buttons,
`else
  input  logic [7:0]                buttons,
`endif
  nes_pad_responder_if.slave        pad,
  output logic                      poll_strobe,
`ifdef NES_PAD_SNES_EN
  output logic [4:0]                bit_idx,
`else
  output logic [3:0]                bit_idx,
`endif
  output logic                      host_active
);

`ifdef NES_PAD_SNES_EN
  localparam int FRAME_BITS = 16;
  localparam int IDX_W      = 5;
`else
  localparam int FRAME_BITS = 8;
  localparam int IDX_W      = 4;
`endif

  localparam logic [23:0]      TIMEOUT_VAL = 24'(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(FRAME_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] latch_sync_q, latch_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic                   latch_prev_q, latch_prev_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic [FRAME_BITS-1:0]  shreg_q, shreg_d;
  logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
  logic [23:0]            tmo_cnt_q, tmo_cnt_d;
  logic                   data_q, data_d;
  logic                   poll_q, poll_d;
  logic                   active_q, active_d;

  logic                   latch_rise, latch_fall, sclk_rise;
  logic                   timeout_now, shift_en;
  logic [FRAME_BITS-1:0]  load_val;

  // Unused SNES positions load as released so they shift out as 1.
`ifdef NES_PAD_SNES_EN
  assign load_val = {4'b0000, buttons};
`else
  assign load_val = buttons;
`endif

  // ---------------------------------------------------------------------------
  // State register: every flop of the block lives here.
  // ---------------------------------------------------------------------------
  // NOTE: clocked state is written with non-blocking assignments so every flop
  // samples its _d from the same pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      latch_sync_q <= '0;
      sclk_sync_q  <= '0;
      latch_prev_q <= 1'b0;
      sclk_prev_q  <= 1'b0;
      shreg_q      <= '0;
      bit_idx_q    <= '0;
      tmo_cnt_q    <= '0;
      data_q       <= 1'b1;
      poll_q       <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      latch_sync_q <= latch_sync_d;
      sclk_sync_q  <= sclk_sync_d;
      latch_prev_q <= latch_prev_d;
      sclk_prev_q  <= sclk_prev_d;
      shreg_q      <= shreg_d;
      bit_idx_q    <= bit_idx_d;
      tmo_cnt_q    <= tmo_cnt_d;
      data_q       <= data_d;
      poll_q       <= poll_d;
      active_q     <= active_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Input conditioning, edge detection and the host-activity timeout.
  // ---------------------------------------------------------------------------
  always_comb begin
    latch_sync_d = {latch_sync_q[SYNC_STAGES-2:0], pad.nes_latch_in};
    sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], pad.nes_clk_in};
    latch_prev_d = latch_sync_q[SYNC_STAGES-1];
    sclk_prev_d  = sclk_sync_q[SYNC_STAGES-1];

    latch_rise =  latch_sync_q[SYNC_STAGES-1] & ~latch_prev_q;
    latch_fall = ~latch_sync_q[SYNC_STAGES-1] &  latch_prev_q;
    sclk_rise  =  sclk_sync_q[SYNC_STAGES-1]  & ~sclk_prev_q;

    // Counter saturates, so once expired timeout_now holds the FSM in IDLE
    // until the next latch rise clears it.
    if (latch_rise)                    tmo_cnt_d = '0;
    else if (tmo_cnt_q == TIMEOUT_VAL) tmo_cnt_d = tmo_cnt_q;
    else                               tmo_cnt_d = tmo_cnt_q + 24'd1;

    timeout_now = !latch_rise && (tmo_cnt_d == TIMEOUT_VAL);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. A latch rise wins over everything, including a host
  // clock rise in the same cycle and an expiring timeout.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d = state_q;
    if (latch_rise) begin
      state_d = ST_LOAD;
    end else if (timeout_now) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_LOAD:  if (latch_fall) state_d = ST_SHIFT;
        ST_SHIFT: if (sclk_rise && (bit_idx_q == IDX_LAST)) state_d = ST_DONE;
        default:  state_d = state_q;   // IDLE and DONE ignore host clocks
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output / datapath logic, all registered. The serial line value is derived
  // from the state being entered, so it changes on the same edge as the FSM.
  // ---------------------------------------------------------------------------
  always_comb begin
    shift_en  = (state_q == ST_SHIFT) && sclk_rise &&
                ((state_d == ST_SHIFT) || (state_d == ST_DONE));
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;

    if (state_d == ST_LOAD) begin
      // Transparent load: follows buttons every cycle while the latch is high.
      shreg_d   = load_val;
      bit_idx_d = '0;
    end else if (shift_en) begin
      shreg_d   = {1'b0, shreg_q[FRAME_BITS-1:1]};
      bit_idx_d = bit_idx_q + IDX_ONE;
    end

    case (state_d)
      ST_IDLE:  data_d = 1'b1;
      ST_LOAD:  data_d = ~load_val[0];
      ST_SHIFT: data_d = ~shreg_d[0];
      default:  data_d = 1'b0;          // DONE: grounded serial input reads as pressed
    endcase

    poll_d = (state_q == ST_LOAD) && (state_d == ST_SHIFT);

    if (latch_rise)       active_d = 1'b1;
    else if (timeout_now) active_d = 1'b0;
    else                  active_d = active_q;
  end

  assign pad.nes_data_out = data_q;
  assign poll_strobe      = poll_q;
  assign bit_idx          = bit_idx_q;
  assign host_active      = active_q;

endmodule

// File: doc/nes_pad_responder.md
Name: nes_pad_responder

Overview:
- Controller-side end of the NES serial pad protocol: emulates a 4021-style pad, answering a host's latch/clock strobes on a serial data line.
- Paired with the team's NES pad reader peripheral as a synthesizable loopback target and as a standalone pad emulator on spare TT pins.
- Latch and clock from the host are asynchronous to `clk`; they are synchronized, edge-detected, and drive an FSM plus a shift register.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on nes_latch_in and nes_clk_in (min 2).
- TIMEOUT_CYCLES, 1000000, `clk` cycles without a latch rising edge before `host_active` drops; 24-bit counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- buttons  input  8  active-high pressed; [0]=A [1]=B [2]=Select [3]=Start [4]=Up [5]=Down [6]=Left [7]=Right
- nes_latch_in  input  1  host latch, async, active-high
- nes_clk_in  input  1  host shift clock, async; shift on rising edge
- nes_data_out  output  1  serial data, active-low (0 = pressed)
- poll_strobe  output  1  one-cycle pulse on synchronized latch falling edge
- bit_idx  output  4  bits shifted since last load, saturates at 8
- host_active  output  1  latch seen within TIMEOUT_CYCLES

Behaviour:
- Reset (async assert, sync-released internally by the flops):
  - nes_data_out=1, poll_strobe=0, bit_idx=0, host_active=0.
  - Shift reg=0, FSM=IDLE, timeout counter=0.
- Inputs pass through SYNC_STAGES flops, then one edge-detect flop. Edges are acted on the cycle after detection. Total latency from pin edge to nes_data_out change: SYNC_STAGES+1 `clk` cycles (3 at default).
- FSM states and transitions:
  - IDLE: latch rise → LOAD.
  - LOAD: shift reg reloads from `buttons` every cycle (transparent parallel load). nes_data_out = ~buttons[0] live, registered. bit_idx=0. Host clock edges are ignored. Latch fall → SHIFT, poll_strobe=1 for one cycle, last loaded value frozen.
  - SHIFT: each synced clk rise shifts right, inserting 0. bit_idx++. nes_data_out = ~shreg[0] after the shift. When bit_idx reaches 8 → DONE.
  - DONE: nes_data_out=0 (4021 serial input grounded; host reads 1s). Further clk rises are ignored; bit_idx stays 8.
  - Latch rise from any state → LOAD. This abandons a partial shift; a new poll mid-read is legal.
- Simultaneous synced latch rise and clk rise in the same cycle: latch wins, no shift.
- Clock rise in IDLE: ignored; nes_data_out stays 1.
- Timeout counter:
  - Cleared, and host_active set, on each latch rise.
  - Otherwise increments, saturating at TIMEOUT_CYCLES.
  - At equality, host_active=0 and FSM → IDLE, nes_data_out=1.
- Reset mid-shift: immediate return to reset values; host sees nes_data_out=1 within reset assertion.
- `buttons` is sampled only in LOAD. Changes during SHIFT do not affect the frame.

Optional Feature:
- Macro NES_PAD_SNES_EN.
- Defined: SNES mode.
  - `buttons` widens to 12: [0]=B [1]=Y [2]=Select [3]=Start [4]=Up [5]=Down [6]=Left [7]=Right [8]=A [9]=X [10]=L [11]=R.
  - Shift reg 16 bits; bits 12–15 load as released (line 1).
  - bit_idx saturates at 16; DONE after 16 shifts.
- Undefined: 8-bit NES behaviour exactly as above; `buttons` is 8 bits.

Test Plan:
- Reset → nes_data_out=1, bit_idx=0, host_active=0, poll_strobe=0 throughout reset.
- buttons=8'b0000_1001, latch high 12 µs then low, 8 clk pulses → serial line reads 0,1,1,0,1,1,1,1. Then 0 on 9th/10th pulses. poll_strobe pulses once; bit_idx ends at 8.
- Change buttons from 0x01 to 0x80 during LOAD → data follows (line 0 then 1 within 1 cycle). Change to 0xFF during SHIFT after 3 bits → remaining bits unaffected.
- After 4 clk pulses, new latch pulse with buttons=0x02 → bit_idx=0, full fresh frame 1,0,1,1,1,1,1,1.
- Set TIMEOUT_CYCLES=100, one poll, then idle 100 cycles → host_active falls exactly at count 100, nes_data_out=1. Next latch rise reasserts host_active.
- With NES_PAD_SNES_EN, buttons=12'h801 → 16 bits: 0, then 1×10, then 0 (R), then 1×4, then 0 after; bit_idx=16.
